// File: rtl/multi_candidate_vote_logger_if.sv
// Bundle of vote inputs and tally/readout outputs for multi_candidate_vote_logger.
// The tally side drives the outputs; the voting/readout side drives the inputs.
interface multi_candidate_vote_logger_if #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
);
  localparam int unsigned SEL_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
  localparam int unsigned TOT_W = CNT_W + SEL_W;

  logic                      mode;
  logic [NUM_CAND-1:0]       vote_valid;
  logic                      clear;
  logic [SEL_W-1:0]          sel_cand;
  logic [NUM_CAND*CNT_W-1:0] vote_counts;
  logic [TOT_W-1:0]          total_votes;
  logic [CNT_W-1:0]          sel_count;
  logic [SEL_W-1:0]          leader;
  logic [NUM_CAND-1:0]       saturated;
  logic                      vote_accepted;

  modport master (
    output mode, vote_valid, clear, sel_cand,
    input  vote_counts, total_votes, sel_count, leader, saturated, vote_accepted
  );

  modport slave (
    input  mode, vote_valid, clear, sel_cand,
    output vote_counts, total_votes, sel_count, leader, saturated, vote_accepted
  );
endinterface

// File: rtl/multi_candidate_vote_logger.sv
// Per-candidate saturating vote tally with press edge detection, leader tracking,
// synchronous clear in readout mode and a combinational per-candidate readout.
module multi_candidate_vote_logger #(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  multi_candidate_vote_logger_if.slave bus
);
  localparam int unsigned SEL_W = ($clog2(NUM_CAND) > 1) ? $clog2(NUM_CAND) : 1;
  localparam int unsigned TOT_W = CNT_W + SEL_W;
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q [NUM_CAND];
  logic [CNT_W-1:0]    count_d [NUM_CAND];
  logic [TOT_W-1:0]    total_q, total_d;
  logic [SEL_W-1:0]    leader_q, leader_d;
  logic [NUM_CAND-1:0] sat_q, sat_d;
  logic                acc_q;

  logic                press_start;
  logic                any_press;
  logic                do_clear;
  logic                inc;
  logic [SEL_W-1:0]    first_idx;
  logic [SEL_W-1:0]    leader_calc;
  logic [CNT_W-1:0]    best_cnt;

  assign any_press = |bus.vote_valid;
  assign do_clear  = bus.mode & bus.clear;

  // Press FSM: state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (any_press)  state_d = StHold;
      StHold: if (!any_press) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A vote is only evaluated on the idle-to-hold cycle, whatever the mode.
  always_comb begin
    press_start = (state_q == StIdle) && any_press;
  end

  // Lowest-index pressed candidate wins when several buttons are down.
  always_comb begin
    first_idx = '0;
    for (int i = int'(NUM_CAND) - 1; i >= 0; i--) begin
      if (bus.vote_valid[i]) first_idx = SEL_W'(i);
    end
  end

  assign inc = press_start && !bus.mode && (count_q[first_idx] != CntMax);

  // Strict greater-than keeps ties on the lowest index.
  always_comb begin
    best_cnt    = count_q[0];
    leader_calc = '0;
    for (int i = 1; i < int'(NUM_CAND); i++) begin
      if (count_q[i] > best_cnt) begin
        best_cnt    = count_q[i];
        leader_calc = SEL_W'(i);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_CAND); i++) count_d[i] = count_q[i];
    total_d  = total_q;
    leader_d = leader_calc;
    if (do_clear) begin
      for (int i = 0; i < int'(NUM_CAND); i++) count_d[i] = '0;
      total_d  = '0;
      leader_d = '0;
    end else if (inc) begin
      count_d[first_idx] = count_q[first_idx] + CNT_W'(1);
      total_d            = total_q + TOT_W'(1);
    end
    for (int i = 0; i < int'(NUM_CAND); i++) sat_d[i] = (count_d[i] == CntMax);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NUM_CAND); i++) count_q[i] <= '0;
      total_q  <= '0;
      leader_q <= '0;
      sat_q    <= '0;
      acc_q    <= 1'b0;
    end else begin
      for (int i = 0; i < int'(NUM_CAND); i++) count_q[i] <= count_d[i];
      total_q  <= total_d;
      leader_q <= leader_d;
      sat_q    <= sat_d;
      acc_q    <= inc;
    end
  end

  always_comb begin
    bus.vote_counts = '0;
    for (int i = 0; i < int'(NUM_CAND); i++) bus.vote_counts[i*CNT_W +: CNT_W] = count_q[i];
  end

  always_comb begin
    bus.sel_count = '0;
    if (bus.mode && (32'(bus.sel_cand) < NUM_CAND)) bus.sel_count = count_q[bus.sel_cand];
  end

  assign bus.total_votes   = total_q;
  assign bus.leader        = leader_q;
  assign bus.saturated     = sat_q;
  assign bus.vote_accepted = acc_q;

endmodule

// File: tb/tb_multi_candidate_vote_logger.sv
// Directed bench: an 8-bit-counter instance walks a vector table; a 4-bit-counter
// instance on the same stimulus covers saturation. Reset cases are hand-sequenced.
module tb_multi_candidate_vote_logger;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       clear;
  logic [3:0] vv;
  logic [1:0] sel;

  int errors = 0;
  int checks = 0;

  multi_candidate_vote_logger_if #(.NUM_CAND(4), .CNT_W(8)) bus8 ();
  multi_candidate_vote_logger_if #(.NUM_CAND(4), .CNT_W(4)) bus4 ();

  assign bus8.mode       = mode;
  assign bus8.clear      = clear;
  assign bus8.vote_valid = vv;
  assign bus8.sel_cand   = sel;
  assign bus4.mode       = mode;
  assign bus4.clear      = clear;
  assign bus4.vote_valid = vv;
  assign bus4.sel_cand   = sel;

  multi_candidate_vote_logger #(.NUM_CAND(4), .CNT_W(8)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (bus8)
  );

  multi_candidate_vote_logger #(.NUM_CAND(4), .CNT_W(4)) dut4 (
    .clock (clock),
    .reset (reset),
    .bus   (bus4)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        mode;
    logic        clear;
    logic [3:0]  vv;
    logic [1:0]  sel;
    logic [31:0] cnt;   // {c3,c2,c1,c0}, 8 bits each
    logic [9:0]  tot;
    logic [1:0]  ldr;
    logic        acc;
    logic [7:0]  sc;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic add(input logic m, input logic c, input logic [3:0] v, input logic [1:0] s,
                     input logic [31:0] cn, input logic [9:0] t, input logic [1:0] l,
                     input logic a, input logic [7:0] sc);
    vec_t r;
    r.mode = m; r.clear = c; r.vv = v; r.sel = s; r.cnt = cn;
    r.tot = t; r.ldr = l; r.acc = a; r.sc = sc;
    tbl.push_back(r);
  endtask

  initial begin
    int pulses4;
    int pulses8;
    int exp_c;

    // m  clr  vv       sel    counts         tot ldr acc sc
    add(0, 0, 4'b0100, 2'd0, 32'h0001_0000, 1, 0, 1, 0);  // press c2
    add(0, 0, 4'b0100, 2'd0, 32'h0001_0000, 1, 2, 0, 0);  // held, leader follows
    add(0, 0, 4'b0100, 2'd0, 32'h0001_0000, 1, 2, 0, 0);
    add(0, 0, 4'b0100, 2'd0, 32'h0001_0000, 1, 2, 0, 0);
    add(0, 0, 4'b0100, 2'd0, 32'h0001_0000, 1, 2, 0, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0001_0000, 1, 2, 0, 0);
    add(0, 0, 4'b1010, 2'd0, 32'h0001_0100, 2, 2, 1, 0);  // c1 wins over c3
    add(0, 0, 4'b0000, 2'd0, 32'h0001_0100, 2, 1, 0, 0);  // tie c1/c2 -> 1
    add(1, 1, 4'b0000, 2'd0, 32'h0000_0000, 0, 0, 0, 0);  // clear
    add(0, 0, 4'b0001, 2'd0, 32'h0000_0001, 1, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0000_0001, 1, 0, 0, 0);
    add(0, 0, 4'b0001, 2'd0, 32'h0000_0002, 2, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0000_0002, 2, 0, 0, 0);
    add(0, 0, 4'b0010, 2'd0, 32'h0000_0102, 3, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0000_0102, 3, 0, 0, 0);
    add(0, 0, 4'b0010, 2'd0, 32'h0000_0202, 4, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0000_0202, 4, 0, 0, 0);
    add(0, 0, 4'b1000, 2'd0, 32'h0100_0202, 5, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0100_0202, 5, 0, 0, 0);
    add(1, 0, 4'b0000, 2'd3, 32'h0100_0202, 5, 0, 0, 1);  // readout c3
    add(0, 1, 4'b0000, 2'd3, 32'h0100_0202, 5, 0, 0, 0);  // clear ignored in voting
    add(1, 0, 4'b0000, 2'd1, 32'h0100_0202, 5, 0, 0, 2);
    add(1, 1, 4'b0000, 2'd3, 32'h0000_0000, 0, 0, 0, 0);  // clear
    add(1, 0, 4'b0000, 2'd0, 32'h0000_0000, 0, 0, 0, 0);
    add(1, 0, 4'b1000, 2'd3, 32'h0000_0000, 0, 0, 0, 0);  // press begins in readout
    add(0, 0, 4'b1000, 2'd3, 32'h0000_0000, 0, 0, 0, 0);  // still held, back to voting
    add(0, 0, 4'b0000, 2'd3, 32'h0000_0000, 0, 0, 0, 0);
    add(0, 0, 4'b1000, 2'd0, 32'h0100_0000, 1, 0, 1, 0);
    add(0, 0, 4'b0000, 2'd0, 32'h0100_0000, 1, 3, 0, 0);
    add(1, 0, 4'b0000, 2'd3, 32'h0100_0000, 1, 3, 0, 1);

    reset = 1'b1; mode = 1'b0; clear = 1'b0; vv = 4'b0; sel = 2'd0;
    #12;
    check("reset counts", 32'(bus8.vote_counts), 32'h0);
    check("reset total", 32'(bus8.total_votes), 32'h0);
    check("reset leader", 32'(bus8.leader), 32'h0);
    check("reset saturated", 32'(bus8.saturated), 32'h0);
    check("reset accepted", 32'(bus8.vote_accepted), 32'h0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      mode = tbl[i].mode; clear = tbl[i].clear; vv = tbl[i].vv; sel = tbl[i].sel;
      tick();
      check($sformatf("v%0d counts", i), 32'(bus8.vote_counts), tbl[i].cnt);
      check($sformatf("v%0d total", i), 32'(bus8.total_votes), 32'(tbl[i].tot));
      check($sformatf("v%0d leader", i), 32'(bus8.leader), 32'(tbl[i].ldr));
      check($sformatf("v%0d accepted", i), 32'(bus8.vote_accepted), 32'(tbl[i].acc));
      check($sformatf("v%0d sel_count", i), 32'(bus8.sel_count), 32'(tbl[i].sc));
      check($sformatf("v%0d saturated", i), 32'(bus8.saturated), 32'h0);
    end

    // Saturation: 17 separate presses on candidate 0
    mode = 1'b0; clear = 1'b0; vv = 4'b0; sel = 2'd0;
    reset = 1'b1;
    #4;
    reset = 1'b0;
    check("sat start counts", 32'(bus4.vote_counts), 32'h0);
    pulses4 = 0;
    pulses8 = 0;
    for (int k = 0; k < 17; k++) begin
      vv = 4'b0001;
      tick();
      pulses4 += int'(bus4.vote_accepted);
      pulses8 += int'(bus8.vote_accepted);
      exp_c = (k + 1 > 15) ? 15 : k + 1;
      check($sformatf("sat press%0d count0", k), 32'(bus4.vote_counts[3:0]), 32'(exp_c));
      check($sformatf("sat press%0d flag0", k), 32'(bus4.saturated[0]), (k >= 14) ? 32'd1 : 32'd0);
      vv = 4'b0000;
      tick();
      pulses4 += int'(bus4.vote_accepted);
      pulses8 += int'(bus8.vote_accepted);
    end
    check("sat pulses", 32'(pulses4), 32'd15);
    check("sat total", 32'(bus4.total_votes), 32'd15);
    check("sat flags", 32'(bus4.saturated), 32'h1);
    check("wide pulses", 32'(pulses8), 32'd17);
    check("wide count0", 32'(bus8.vote_counts), 32'd17);

    // Asynchronous reset while the accept pulse is high and the press is held
    vv = 4'b0010;
    tick();
    check("pre-reset accepted", 32'(bus8.vote_accepted), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check("async counts", 32'(bus8.vote_counts), 32'h0);
    check("async total", 32'(bus8.total_votes), 32'h0);
    check("async accepted", 32'(bus8.vote_accepted), 32'h0);
    check("async saturated4", 32'(bus4.saturated), 32'h0);
    check("async counts4", 32'(bus4.vote_counts), 32'h0);
    vv = 4'b0001;
    #2;
    reset = 1'b0;
    tick();
    check("post-reset counts", 32'(bus8.vote_counts), 32'h1);
    check("post-reset total", 32'(bus8.total_votes), 32'h1);
    check("post-reset accepted", 32'(bus8.vote_accepted), 32'h1);
    tick();
    check("post-reset held", 32'(bus8.vote_counts), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_candidate_vote_logger.md
MULTI_CANDIDATE_VOTE_LOGGER -- requirements
Module: multi_candidate_vote_logger

Interface
REQ-001 Parameter NUM_CAND, default 4: number of candidate channels, legal 2..16.
REQ-002 Parameter CNT_W, default 8: per-candidate counter width, legal 4..16.
REQ-003 Derived SEL_W = max(1, clog2(NUM_CAND)) and TOT_W = CNT_W + SEL_W, both fixed from the two parameters.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. Ports are named clock and reset.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 mode  input  1  0 = voting, 1 = result/readout.
REQ-008 vote_valid  input  NUM_CAND  per-candidate vote button, bit i = candidate i, level-held while pressed.
REQ-009 clear  input  1  synchronous tally clear, honoured only when mode = 1.
REQ-010 sel_cand  input  SEL_W  candidate index for readout.
REQ-011 vote_counts  output  NUM_CAND*CNT_W  registered counts, candidate i in bits [i*CNT_W +: CNT_W].
REQ-012 total_votes  output  TOT_W  registered count of all accepted votes.
REQ-013 sel_count  output  CNT_W  combinational readout of the selected candidate's count.
REQ-014 leader  output  SEL_W  registered index of the candidate with the highest count.
REQ-015 saturated  output  NUM_CAND  registered per-candidate flag; the counter is at all-ones.
REQ-016 vote_accepted  output  1  one-cycle registered pulse when a count increments.

Function
REQ-017 Press FSM, 2 states:
- IDLE -> HOLD when vote_valid != 0, in any mode.
- HOLD -> IDLE when vote_valid == 0.
- All other cases: state holds.
REQ-018 A vote SHALL be evaluated only on the IDLE->HOLD transition cycle; a held press counts at most once, however long it is held.
REQ-019 When several vote_valid bits are set on the evaluation cycle, only the lowest-index set candidate SHALL be considered.
REQ-020 The considered candidate SHALL be incremented by 1 on that clock edge only if mode = 0 and its counter is not all-ones.
REQ-021 When REQ-020 increments:
- total_votes increments by 1;
- vote_accepted = 1 in the following cycle;
- otherwise vote_accepted = 0.
REQ-022 Counters SHALL saturate at 2^CNT_W-1; they never wrap. A vote for a saturated candidate is discarded with no pulse, but still moves the FSM to HOLD.
REQ-023 saturated[i] SHALL equal 1 in the same cycle that vote_counts for candidate i becomes all-ones.
REQ-024 A press that begins while mode = 1 SHALL never count, including after mode returns to 0 while the press is still held.
REQ-025 clear = 1 with mode = 1 SHALL, at the next edge, zero all counts, total_votes, saturated and leader. FSM state is unaffected. clear SHALL be ignored when mode = 0.
REQ-026 leader SHALL be recomputed from the current counts each cycle and registered, giving 1-cycle latency after a count change. Ties resolve to the lowest index; all-zero counts give 0.
REQ-027 sel_count SHALL equal count[sel_cand] when mode = 1 and sel_cand < NUM_CAND; otherwise 0.
REQ-028 total_votes SHALL always equal the sum of vote_counts; TOT_W guarantees it cannot overflow.

Reset
REQ-029 On reset assertion, asynchronously and without waiting for a clock:
- all counts, total_votes, leader, saturated and vote_accepted go to 0;
- the FSM goes to IDLE.
REQ-030 On reset deassertion with vote_valid already non-zero, the FSM SHALL enter HOLD on the first edge and count that press (subject to REQ-020).
REQ-031 Reset asserted mid-HOLD or mid-increment SHALL leave no partial update; the post-reset state is exactly REQ-029.

Verification
REQ-032 Scenario 1 (defaults): mode=0; vote_valid=0100 for 5 cycles, then 0 -> count2=1, total=1, one vote_accepted pulse, leader=2 one cycle after count2 updates.
REQ-033 Scenario 2: vote_valid=1010 pressed together once -> count1=1, count3=0.
REQ-034 Scenario 3 (CNT_W=4): 17 separate press/release cycles on candidate 0 -> count0=15, saturated[0]=1, total=15, exactly 15 pulses.
REQ-035 Scenario 4: press candidate 3 with mode=1, switch mode to 0 while held, then release -> all counts 0, no pulse.
REQ-036 Scenario 5: counts {2,2,0,1} then mode=1 -> leader=0 and sel_cand=3 gives sel_count=1; then clear=1 for one cycle -> counts, total and leader all 0.
REQ-037 Scenario 6: assert reset asynchronously between edges mid-HOLD -> outputs zero immediately. Release reset with vote_valid=0001 held -> count0=1 after the first edge.
